// File: rtl/mu0_control.sv
// MU0 instruction sequencer: drives datapath mux selects, ALU function,
// register enables and the memory request handshake with optional timeout.
module mu0_control #(
  parameter int WAIT_LIMIT = 0,
  parameter int WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_n,
  input  logic       acc_z,
  input  logic       mem_ready,
  output logic       addr_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic [1:0] alu_fs,
  output logic       acc_ce,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       acc_oe,
  output logic       mem_rq,
  output logic       rnw,
  output logic       halted,
  output logic       bus_err
);

  // state | meaning
  // FETCH | read instruction at PC into IR, PC <= PC+1
  // EXEC  | execute opcode held in IR
  // HALT  | stopped after STP or wait-state timeout; exit via reset only
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);
  localparam bit TIMEOUT_EN = (WAIT_LIMIT > 0);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              access;
  logic              timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      bus_err  <= bus_err | timeout;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_sel  = 1'b0;
    x_sel     = 1'b0;
    y_sel     = 1'b0;
    alu_fs    = 2'b00;
    acc_ce    = 1'b0;
    pc_ce     = 1'b0;
    ir_ce     = 1'b0;
    acc_oe    = 1'b0;
    access    = 1'b0;
    rnw       = 1'b1;
    halted    = 1'b0;

    case (state)
      FETCH: begin
        access = 1'b1;
        x_sel  = 1'b1;
        alu_fs = 2'b11;
        ir_ce  = mem_ready;
        pc_ce  = mem_ready;
        if (mem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        case (opcode)
          4'h0: begin
            addr_sel = 1'b1;
            access   = 1'b1;
            acc_ce   = mem_ready;
          end
          4'h1: begin
            addr_sel = 1'b1;
            access   = 1'b1;
            rnw      = 1'b0;
            acc_oe   = 1'b1;
          end
          4'h2, 4'h3: begin
            addr_sel = 1'b1;
            access   = 1'b1;
            alu_fs   = (opcode == 4'h2) ? 2'b01 : 2'b10;
            acc_ce   = mem_ready;
          end
          4'h4, 4'h5, 4'h6: begin
            y_sel = 1'b1;
            pc_ce = (opcode == 4'h4) ? 1'b1 :
                    (opcode == 4'h5) ? !acc_n : !acc_z;
          end
          default: ;
        endcase
        if (access) begin
          if (mem_ready) state_nxt = FETCH;
        end else if (opcode == 4'h7) begin
          state_nxt = HALT;
        end else begin
          state_nxt = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_nxt = FETCH;
    endcase

    // Stall abort: enables here are already 0 since mem_ready is low.
    timeout = TIMEOUT_EN && access && !mem_ready && (wait_cnt == WAIT_LAST);
    if (timeout) state_nxt = HALT;

    if ((state_nxt != state) || !access || mem_ready)
      wait_cnt_nxt = '0;
    else if (&wait_cnt)
      wait_cnt_nxt = wait_cnt;
    else
      wait_cnt_nxt = wait_cnt + 1'b1;

    mem_rq = access && !reset;
    if (reset) begin
      acc_ce = 1'b0;
      pc_ce  = 1'b0;
      ir_ce  = 1'b0;
      acc_oe = 1'b0;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed test-plan steps then random cycles,
// each cycle checked against a behavioural model of the instruction cycle.
module tb_mu0_control;

  localparam int WL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       acc_n, acc_z, mem_ready;
  logic       addr_sel, x_sel, y_sel, acc_ce, pc_ce, ir_ce, acc_oe;
  logic       mem_rq, rnw, halted, bus_err;
  logic [1:0] alu_fs;

  int vectors = 0;
  int miscompares = 0;

  // Model: where the processor is in its instruction cycle.
  bit m_halted, m_executing, m_err;
  int m_waits;

  always #5 clk = ~clk;

  mu0_control #(.WAIT_LIMIT(WL), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .acc_n(acc_n), .acc_z(acc_z),
    .mem_ready(mem_ready), .addr_sel(addr_sel), .x_sel(x_sel), .y_sel(y_sel),
    .alu_fs(alu_fs), .acc_ce(acc_ce), .pc_ce(pc_ce), .ir_ce(ir_ce),
    .acc_oe(acc_oe), .mem_rq(mem_rq), .rnw(rnw), .halted(halted),
    .bus_err(bus_err)
  );

  // {addr_sel,x_sel,y_sel,alu_fs,acc_ce,pc_ce,ir_ce,acc_oe,mem_rq,rnw,halted,bus_err}
  function automatic logic [12:0] expect_out();
    logic as = 0, xs = 0, ys = 0, ace = 0, pce = 0, ice = 0, oe = 0, rq = 0, rw = 1;
    logic [1:0] fs = 2'b00;
    if (m_halted) begin
      // everything idle
    end else if (!m_executing) begin
      rq = 1; xs = 1; fs = 2'b11; ice = mem_ready; pce = mem_ready;
    end else if (opcode == 0) begin
      as = 1; rq = 1; ace = mem_ready;
    end else if (opcode == 1) begin
      as = 1; rq = 1; rw = 0; oe = 1;
    end else if (opcode == 2 || opcode == 3) begin
      as = 1; rq = 1; ace = mem_ready; fs = (opcode == 2) ? 2'b01 : 2'b10;
    end else if (opcode >= 4 && opcode <= 6) begin
      ys = 1;
      if (opcode == 4) pce = 1;
      if (opcode == 5) pce = !acc_n;
      if (opcode == 6) pce = !acc_z;
    end
    if (reset) begin
      ace = 0; pce = 0; ice = 0; oe = 0; rq = 0;
    end
    return {as, xs, ys, fs, ace, pce, ice, oe, rq, rw, m_halted, m_err};
  endfunction

  function automatic bit model_access();
    return !m_halted && (!m_executing || opcode <= 3);
  endfunction

  task automatic model_clock();
    if (reset) begin
      m_halted = 0; m_executing = 0; m_waits = 0; m_err = 0;
    end else if (m_halted) begin
      // only reset leaves halt
    end else if (model_access()) begin
      if (mem_ready) begin
        m_executing = !m_executing; m_waits = 0;
      end else if (m_waits == WL - 1) begin
        m_halted = 1; m_err = 1; m_waits = 0;
      end else begin
        m_waits++;
      end
    end else begin
      if (opcode == 7) m_halted = 1;
      else m_executing = 0;
      m_waits = 0;
    end
  endtask

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] op,
                      input logic n, input logic z, input logic rdy);
    reset = r; opcode = op; acc_n = n; acc_z = z; mem_ready = rdy;
    @(negedge clk);
    check(tag, {addr_sel, x_sel, y_sel, alu_fs, acc_ce, pc_ce, ir_ce, acc_oe,
                mem_rq, rnw, halted, bus_err}, expect_out());
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    reset = 1; opcode = 0; acc_n = 0; acc_z = 0; mem_ready = 0;
    @(posedge clk);
    model_clock();
    #1;

    // LDA, zero wait
    step("lda_fetch", 0, 4'h0, 0, 0, 1);
    step("lda_exec",  0, 4'h0, 0, 0, 1);
    // STA with three wait states
    step("sta_fetch", 0, 4'h1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("sta_wait", 0, 4'h1, 0, 0, 0);
    step("sta_done",  0, 4'h1, 0, 0, 1);
    // conditional jumps, both outcomes
    step("jge_fetch", 0, 4'h5, 1, 0, 1);
    step("jge_n1",    0, 4'h5, 1, 0, 1);
    step("jge_fetch", 0, 4'h5, 0, 0, 1);
    step("jge_n0",    0, 4'h5, 0, 0, 1);
    step("jne_fetch", 0, 4'h6, 0, 1, 1);
    step("jne_z1",    0, 4'h6, 0, 1, 1);
    step("jne_fetch", 0, 4'h6, 0, 0, 1);
    step("jne_z0",    0, 4'h6, 0, 0, 1);
    step("jmp_fetch", 0, 4'h4, 0, 0, 1);
    step("jmp_exec",  0, 4'h4, 1, 1, 1);
    step("nop_fetch", 0, 4'hB, 0, 0, 1);
    step("nop_exec",  0, 4'hB, 0, 0, 1);
    // STP then halt while inputs toggle
    step("stp_fetch", 0, 4'h7, 0, 0, 1);
    step("stp_exec",  0, 4'h7, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      step("halt_hold", 0, 4'($urandom), i[0], i[1], i[0]);
    check("halted_after_stp", {12'd0, halted}, 13'd1);
    step("halt_reset", 1, 4'h0, 0, 0, 1);
    check("halt_cleared", {12'd0, halted}, 13'd0);

    // timeout: ready never comes in fetch
    for (int i = 0; i < WL; i++) step("to_fetch", 0, 4'h0, 0, 0, 0);
    check("timeout_bus_err", {11'd0, halted, bus_err}, 13'b11);
    step("to_halt", 0, 4'h0, 0, 0, 1);
    step("to_reset", 1, 4'h0, 0, 0, 0);
    check("bus_err_cleared", {12'd0, bus_err}, 13'd0);
    // ready arrives in the limit cycle
    for (int i = 0; i < WL - 1; i++) step("lim_wait", 0, 4'h2, 0, 0, 0);
    step("lim_ready", 0, 4'h2, 0, 0, 1);
    check("limit_no_err", {11'd0, halted, bus_err}, 13'b00);

    // reset during second wait cycle of ADD
    step("add_exec_w1", 0, 4'h2, 0, 0, 0);
    step("add_reset",   1, 4'h2, 0, 0, 0);
    step("after_reset", 0, 4'h2, 0, 0, 1);

    // random traffic, first mostly ready then heavily stalled
    for (int i = 0; i < 3000; i++) begin
      logic r, rdy;
      r   = ($urandom_range(0, 59) == 0);
      rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
      step("random", r, 4'($urandom), 1'($urandom), 1'($urandom), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
